// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, and stalls on the iterative divider.
module mips_multicycle_control #(
   parameter logic [5:0] DIV_FUNCT      = 6'b011010,
   parameter int         DIV_MAX_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       div_done,
   output logic [3:0] state,
   output logic       pc_en,
   output logic       pc_write,
   output logic       branch,
   output logic [1:0] pc_src,
   output logic       iord,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       div_start,
   output logic       div_timeout
);

   localparam int              WD_W     = $clog2(DIV_MAX_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DIV_MAX_CYCLES);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMRD    = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWR    = 4'd5;
   localparam logic [3:0] S_EXEC     = 4'd6;
   localparam logic [3:0] S_ALUWB    = 4'd7;
   localparam logic [3:0] S_BRANCH   = 4'd8;
   localparam logic [3:0] S_ADDIEXEC = 4'd9;
   localparam logic [3:0] S_ADDIWB   = 4'd10;
   localparam logic [3:0] S_JUMP     = 4'd11;
   localparam logic [3:0] S_DIVWAIT  = 4'd12;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   logic [3:0]      state_q;
   logic [3:0]      state_d;
   logic [3:0]      dec_state;
   logic [WD_W-1:0] wd_cnt;
   logic            is_div;
   logic            wd_expired;
   logic            pc_write_dec;
   logic            ir_write_dec;
   logic            mem_write_dec;
   logic            reg_write_dec;

   assign state      = state_q;
   assign is_div     = (funct == DIV_FUNCT);
   assign wd_expired = (wd_cnt == WD_LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         wd_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DIVWAIT) begin
            if (!wd_expired) wd_cnt <= wd_cnt + WD_W'(1);
         end else begin
            wd_cnt <= '0;
         end
      end
   end

   // NOTE: every always_comb output gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEXEC;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:    state_d = S_MEMWB;
         S_EXEC:     state_d = is_div ? S_DIVWAIT : S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         // div_done wins over a simultaneous watchdog expiry
         S_DIVWAIT: begin
            if (div_done)        state_d = S_ALUWB;
            else if (wd_expired) state_d = S_FETCH;
            else                 state_d = S_DIVWAIT;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // While in reset the mux selects decode as FETCH; strobes are gated below.
   assign dec_state = rst_n ? state_q : S_FETCH;

   always_comb begin
      pc_write_dec  = 1'b0;
      ir_write_dec  = 1'b0;
      mem_write_dec = 1'b0;
      reg_write_dec = 1'b0;
      branch        = 1'b0;
      pc_src        = 2'b00;
      iord          = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      case (dec_state)
         S_FETCH: begin
            ir_write_dec = 1'b1;
            pc_write_dec = 1'b1;
            alu_src_b    = 2'b01;
         end
         S_DECODE: alu_src_b = 2'b11;
         S_MEMADR, S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: iord = 1'b1;
         S_MEMWB: begin
            reg_write_dec = 1'b1;
            mem_to_reg    = 1'b1;
         end
         S_MEMWR: begin
            iord          = 1'b1;
            mem_write_dec = 1'b1;
         end
         S_EXEC, S_DIVWAIT: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write_dec = 1'b1;
            reg_dst       = 1'b1;
         end
         S_ADDIWB: reg_write_dec = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            branch    = 1'b1;
            pc_src    = 2'b01;
         end
         S_JUMP: begin
            pc_write_dec = 1'b1;
            pc_src       = 2'b10;
         end
         default: ;
      endcase
   end

   assign pc_write    = rst_n & pc_write_dec;
   assign ir_write    = rst_n & ir_write_dec;
   assign mem_write   = rst_n & mem_write_dec;
   assign reg_write   = rst_n & reg_write_dec;
   assign pc_en       = rst_n & (pc_write_dec | (branch & zero));
   assign div_start   = rst_n & (state_q == S_EXEC) & is_div;
   assign div_timeout = rst_n & (state_q == S_DIVWAIT) & wd_expired & ~div_done;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: per-instruction vector
// table plus hand-written DIV, watchdog and reset sequences.
module tb_mips_multicycle_control;

   localparam logic [5:0] DIVF = 6'b011010;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       div_done;
   logic [3:0] state;
   logic       pc_en, pc_write, branch, iord, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, div_start, div_timeout;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [17:0] outs;

   int passed = 0;
   int total  = 0;
   logic [21:0] sb_q[$];

   mips_multicycle_control #(.DIV_FUNCT(DIVF), .DIV_MAX_CYCLES(64)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .div_done(div_done), .state(state), .pc_en(pc_en), .pc_write(pc_write),
      .branch(branch), .pc_src(pc_src), .iord(iord), .mem_write(mem_write),
      .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .div_start(div_start), .div_timeout(div_timeout)
   );

   always #5 clk = ~clk;

   assign outs = {pc_en, pc_write, branch, pc_src, iord, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, div_start, div_timeout};

   typedef struct packed {
      logic [5:0]      op;
      logic [5:0]      fn;
      logic            z;
      logic            dd;
      logic [2:0]      len;
      logic [4:0][3:0] seq;
   } vec_t;

   function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                               input logic dd, input logic [2:0] len,
                               input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                               input logic [3:0] s3, input logic [3:0] s4);
      vec_t v;
      v.op = op; v.fn = fn; v.z = z; v.dd = dd; v.len = len;
      v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
      return v;
   endfunction

   // Expected Moore outputs per state, written out from the control table.
   function automatic logic [17:0] exp_outs(input logic [3:0] s, input logic z,
                                            input logic [5:0] fn, input logic to);
      logic pcw = 1'b0, br = 1'b0, io = 1'b0, mw = 1'b0, irw = 1'b0, rd = 1'b0;
      logic m2r = 1'b0, rw = 1'b0, asa = 1'b0, ds = 1'b0;
      logic [1:0] psrc = 2'b00, asb = 2'b00, aop = 2'b00;
      case (s)
         4'd0:  begin irw = 1'b1; pcw = 1'b1; asb = 2'b01; end
         4'd1:  asb = 2'b11;
         4'd2, 4'd9: begin asa = 1'b1; asb = 2'b10; end
         4'd3:  io = 1'b1;
         4'd4:  begin rw = 1'b1; m2r = 1'b1; end
         4'd5:  begin io = 1'b1; mw = 1'b1; end
         4'd6:  begin asa = 1'b1; aop = 2'b10; ds = (fn == DIVF); end
         4'd12: begin asa = 1'b1; aop = 2'b10; end
         4'd7:  begin rw = 1'b1; rd = 1'b1; end
         4'd10: rw = 1'b1;
         4'd8:  begin asa = 1'b1; aop = 2'b01; br = 1'b1; psrc = 2'b01; end
         4'd11: begin pcw = 1'b1; psrc = 2'b10; end
         default: ;
      endcase
      return {pcw | (br & z), pcw, br, psrc, io, mw, irw, rd, m2r, rw, asa, asb, aop, ds, to};
   endfunction

   // During reset: FETCH mux selects (alu_src_b = 01), every strobe low.
   localparam logic [17:0] RESET_OUTS = 18'b0000_0000_0000_0100_00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   task automatic step(input logic [3:0] es, input logic [17:0] eo, input logic dd,
                       input string tag);
      logic [21:0] e;
      div_done = dd;
      sb_q.push_back({es, eo});
      @(negedge clk);
      e = sb_q.pop_front();
      check({tag, " state"}, 32'(state), 32'(e[21:18]));
      check({tag, " outs"}, 32'(outs), 32'(e[17:0]));
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      opcode = v.op; funct = v.fn; zero = v.z;
      for (int i = 0; i < int'(v.len); i++)
         step(v.seq[i], exp_outs(v.seq[i], v.z, v.fn, 1'b0), v.dd, $sformatf("%s c%0d", tag, i));
   endtask

   task automatic div_prefix(input string tag);
      opcode = 6'b000000; funct = DIVF; zero = 1'b0;
      step(4'd0, exp_outs(4'd0, 1'b0, DIVF, 1'b0), 1'b0, {tag, " fetch"});
      step(4'd1, exp_outs(4'd1, 1'b0, DIVF, 1'b0), 1'b0, {tag, " decode"});
      step(4'd6, exp_outs(4'd6, 1'b0, DIVF, 1'b0), 1'b0, {tag, " exec"});
   endtask

   vec_t vecs[9];

   initial begin
      #2_000_000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = mk(6'b100011, 6'h00,   1'b0, 1'b0, 3'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
      vecs[1] = mk(6'b101011, 6'h00,   1'b0, 1'b0, 3'd4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0);
      vecs[2] = mk(6'b000000, 6'h20,   1'b0, 1'b0, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0);
      vecs[3] = mk(6'b000000, 6'h20,   1'b1, 1'b1, 3'd4, 4'd0, 4'd1, 4'd6, 4'd7, 4'd0);
      vecs[4] = mk(6'b001000, 6'h00,   1'b0, 1'b0, 3'd4, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0);
      vecs[5] = mk(6'b000100, 6'h00,   1'b1, 1'b0, 3'd3, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0);
      vecs[6] = mk(6'b000100, 6'h00,   1'b0, 1'b0, 3'd3, 4'd0, 4'd1, 4'd8, 4'd0, 4'd0);
      vecs[7] = mk(6'b000010, 6'h00,   1'b1, 1'b0, 3'd3, 4'd0, 4'd1, 4'd11, 4'd0, 4'd0);
      vecs[8] = mk(6'b111111, 6'h3f,   1'b1, 1'b1, 3'd2, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0);

      rst_n = 1'b0; opcode = 6'b100011; funct = 6'h00; zero = 1'b0; div_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("reset state", 32'(state), 32'd0);
         check("reset outs", 32'(outs), 32'(RESET_OUTS));
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // DIV: done seen in the 5th DIVWAIT cycle, then ALUWB.
      div_prefix("div");
      for (int i = 1; i <= 5; i++)
         step(4'd12, exp_outs(4'd12, 1'b0, DIVF, 1'b0), (i == 5), $sformatf("div wait%0d", i));
      step(4'd7, exp_outs(4'd7, 1'b0, DIVF, 1'b0), 1'b0, "div aluwb");

      // Watchdog expiry: no done, timeout pulse then FETCH.
      div_prefix("wd");
      for (int i = 1; i <= 64; i++)
         step(4'd12, exp_outs(4'd12, 1'b0, DIVF, 1'b0), 1'b0, $sformatf("wd wait%0d", i));
      step(4'd12, exp_outs(4'd12, 1'b0, DIVF, 1'b1), 1'b0, "wd expire");
      step(4'd0, exp_outs(4'd0, 1'b0, DIVF, 1'b0), 1'b0, "wd fetch");
      step(4'd1, exp_outs(4'd1, 1'b0, DIVF, 1'b0), 1'b0, "wd2 decode");
      step(4'd6, exp_outs(4'd6, 1'b0, DIVF, 1'b0), 1'b0, "wd2 exec");

      // Done arriving on the expiry cycle wins: no timeout, ALUWB.
      for (int i = 1; i <= 64; i++)
         step(4'd12, exp_outs(4'd12, 1'b0, DIVF, 1'b0), 1'b0, $sformatf("wd2 wait%0d", i));
      step(4'd12, exp_outs(4'd12, 1'b0, DIVF, 1'b0), 1'b1, "wd2 expire+done");
      step(4'd7, exp_outs(4'd7, 1'b0, DIVF, 1'b0), 1'b0, "wd2 aluwb");

      // Reset while stalled in DIVWAIT.
      div_prefix("rst");
      for (int i = 1; i <= 3; i++)
         step(4'd12, exp_outs(4'd12, 1'b0, DIVF, 1'b0), 1'b0, $sformatf("rst wait%0d", i));
      rst_n = 1'b0;
      step(4'd12, RESET_OUTS, 1'b0, "rst in divwait");
      step(4'd0, RESET_OUTS, 1'b0, "rst after edge");
      rst_n = 1'b1;
      run_vec(vecs[0], "post-rst lw");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
